// File: rtl/mips_pkg.sv
// Purpose: shared access-size encoding, memory-stage FSM state type and size helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // A dword request on a 32-bit datapath cannot be honoured; treat it as a word.
    function automatic logic [1:0] clamp_size(input logic [1:0] sz, input int data_w);
        logic [1:0] res;
        res = sz;
        if (data_w < 64 && sz == SZ_DWORD) begin
            res = SZ_WORD;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purpose: byte-lane enables, store-data lane replication and load-data shift/extend.
// Latency: purely combinational.
// Backpressure: none; caller must present a size-aligned offset.
module mem_lane_align
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic              sext_i,
    input  logic [DATA_W-1:0] st_val_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [NB-1:0]     be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ld_val_o
);

    logic [NB-1:0]     be_base;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;

    // Per-size lane mask and sign position, then shift lanes into place.
    always_comb begin
        be_base   = '0;
        keep_mask = '0;
        sign_bit  = 1'b0;
        shifted   = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                be_base   = NB'(8'h01);
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = shifted[7];
            end
            SZ_HALF: begin
                be_base   = NB'(8'h03);
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            SZ_WORD: begin
                be_base   = NB'(8'h0F);
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                be_base   = '1;
                keep_mask = '1;
                sign_bit  = shifted[DATA_W-1];
            end
        endcase
        be_o     = be_base << off_i;
        ld_val_o = (shifted & keep_mask) | (~keep_mask & {DATA_W{sext_i & sign_bit}});
    end

    // Offsets are size-aligned, so lane i carries store byte (i mod size).
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign wdata_o[8*i +: 8] = (size_i == SZ_BYTE) ? st_val_i[7:0] :
                                   (size_i == SZ_HALF) ? st_val_i[8*(i%2) +: 8] :
                                   (size_i == SZ_WORD) ? st_val_i[8*(i%4) +: 8] :
                                                         st_val_i[8*(i%NB) +: 8];
    end

endmodule

// File: rtl/mem_stage_mc.sv
// Purpose: multi-cycle load/store stage (IDLE/ACCESS/DONE) with timeout; MEM_STAGE_MISALIGN_CHK_EN enables alignment errors.
// Latency: request cycle + ACCESS cycles until sram_ready (>=1) + one DONE cycle.
// Backpressure: mem_busy freezes the pipeline from the request cycle until DONE; requests outside IDLE are ignored.
module mem_stage_mc
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MEM_R_EN_in,
    input  logic                MEM_W_EN_in,
    input  logic [1:0]          size_in,
    input  logic                sign_ext_in,
    input  logic [DATA_W-1:0]   ALU_result_in,
    input  logic [DATA_W-1:0]   ST_val,
    output logic [DATA_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W/8-1:0] sram_be,
    output logic                sram_re,
    output logic                sram_we,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic                sram_ready,
    output logic                mem_busy,
    output logic [DATA_W-1:0]   MEM_read_value,
    output logic                rd_valid,
    output logic                mem_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_ld_q, sext_q, fail_q, err_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] addr_q, st_q, rval_q;

    logic              req, misal, is_idle;
    logic              misal_err, timeout;
    logic [1:0]        sz_eff;
    logic [DATA_W-1:0] low_mask, addr_al;
    logic [1:0]        lane_size;
    logic [OFF_W-1:0]  lane_off;
    logic [DATA_W-1:0] lane_st, lane_wdata, lane_ld;
    logic [NB-1:0]     lane_be;

    // Gating with rst_n keeps every output low while reset is held.
    assign req      = rst_n & (MEM_R_EN_in | MEM_W_EN_in);
    assign sz_eff   = clamp_size(size_in, DATA_W);
    assign low_mask = DATA_W'((8'd1 << sz_eff) - 8'd1);
    assign addr_al  = ALU_result_in & ~low_mask;
    assign is_idle  = (state_q == ST_IDLE);

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    assign misal = |(ALU_result_in & low_mask);
`else
    assign misal = 1'b0;
`endif

    // Lane logic sees the live request in IDLE and the latched request afterwards.
    assign lane_size = is_idle ? sz_eff : size_q;
    assign lane_off  = is_idle ? addr_al[OFF_W-1:0] : addr_q[OFF_W-1:0];
    assign lane_st   = is_idle ? ST_val : st_q;

    mem_lane_align #(.DATA_W(DATA_W)) u_lane (
        .size_i   (lane_size),
        .off_i    (lane_off),
        .sext_i   (sext_q),
        .st_val_i (lane_st),
        .rdata_i  (sram_rdata),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .ld_val_o (lane_ld)
    );

    // Next state and memory-request outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_be    = '0;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        mem_busy   = 1'b0;
        misal_err  = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    mem_busy = 1'b1;
                    cnt_d    = '0;
                    if (misal) begin
                        misal_err = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        sram_re    = ~MEM_W_EN_in;
                        sram_we    = MEM_W_EN_in;
                        sram_addr  = addr_al;
                        sram_wdata = lane_wdata;
                        sram_be    = lane_be;
                        state_d    = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                mem_busy   = 1'b1;
                sram_re    = is_ld_q;
                sram_we    = ~is_ld_q;
                sram_addr  = addr_q;
                sram_wdata = lane_wdata;
                sram_be    = lane_be;
                if (sram_ready) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and ACCESS wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch, load result capture and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_ld_q <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            st_q    <= '0;
            fail_q  <= 1'b0;
            rval_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (is_idle && req) begin
                is_ld_q <= ~MEM_W_EN_in;
                sext_q  <= sign_ext_in;
                size_q  <= sz_eff;
                addr_q  <= addr_al;
                st_q    <= ST_val;
                fail_q  <= misal;
            end
            if (timeout) begin
                fail_q <= 1'b1;
            end
            if (state_q == ST_ACCESS && sram_ready && is_ld_q) begin
                rval_q <= lane_ld;
            end
            if (misal_err || timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rd_valid       = (state_q == ST_DONE) && is_ld_q && !fail_q;
    assign MEM_read_value = rval_q;
    assign mem_err        = err_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
module tb_mem_stage_mc;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          MEM_R_EN_in, MEM_W_EN_in;
    logic [1:0]    size_in;
    logic          sign_ext_in;
    logic [DW-1:0] ALU_result_in, ST_val;
    logic [DW-1:0] sram_addr, sram_wdata;
    logic [DW/8-1:0] sram_be;
    logic          sram_re, sram_we;
    logic [DW-1:0] sram_rdata;
    logic          sram_ready;
    logic          mem_busy;
    logic [DW-1:0] MEM_read_value;
    logic          rd_valid, mem_err;

    always #5 clk = ~clk;

    mem_stage_mc #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .MEM_W_EN_in    (MEM_W_EN_in),
        .size_in        (size_in),
        .sign_ext_in    (sign_ext_in),
        .ALU_result_in  (ALU_result_in),
        .ST_val         (ST_val),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_be        (sram_be),
        .sram_re        (sram_re),
        .sram_we        (sram_we),
        .sram_rdata     (sram_rdata),
        .sram_ready     (sram_ready),
        .mem_busy       (mem_busy),
        .MEM_read_value (MEM_read_value),
        .rd_valid       (rd_valid),
        .mem_err        (mem_err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_val;
    logic        exp_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_R_EN_in   = 1'b0;
        MEM_W_EN_in   = 1'b0;
        size_in       = 2'd0;
        sign_ext_in   = 1'b0;
        ALU_result_in = '0;
        ST_val        = '0;
        sram_ready    = 1'b0;
        sram_rdata    = $urandom;
    endtask

    // Requests presented while the stage is busy must be ignored.
    task automatic junk_inputs();
        MEM_R_EN_in   = 1'($urandom_range(0, 1));
        MEM_W_EN_in   = 1'($urandom_range(0, 1));
        size_in       = 2'($urandom_range(0, 2));
        sign_ext_in   = 1'($urandom_range(0, 1));
        ALU_result_in = $urandom;
        ST_val        = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_re"},    sram_re,        0);
        chk({tag, "_we"},    sram_we,        0);
        chk({tag, "_busy"},  mem_busy,       0);
        chk({tag, "_rdv"},   rd_valid,       0);
        chk({tag, "_err"},   mem_err,        exp_err);
        chk({tag, "_value"}, MEM_read_value, exp_val);
    endtask

    // One transaction: request cycle, ACCESS cycles, DONE cycle, one idle cycle.
    task automatic run_txn(input bit is_st, input logic [1:0] sz, input logic [31:0] addr,
                           input bit sx, input logic [31:0] st, input logic [31:0] rd,
                           input int dly);
        int          n, off, k, busy_cnt, exp_busy, bev;
        logic [31:0] al;
        logic [63:0] raw, piece, wd;
        logic [3:0]  e_be;
        bit          misal, fail;
        n     = 1 << sz;
        al    = addr - (addr % n);
        off   = int'(al % 4);
        bev   = ((1 << n) - 1) << off;
        e_be  = bev[3:0];
        piece = 64'(st) % (64'd1 << (8 * n));
        wd    = 64'd0;
        for (int r = 0; r < 4 / n; r++) wd = wd + (piece << (8 * n * r));
        raw = (64'(rd) >> (8 * off)) % (64'd1 << (8 * n));
        if (sx && raw >= (64'd1 << (8 * n - 1))) raw = raw - (64'd1 << (8 * n));
        misal = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        misal = (addr % n) != 0;
`endif
        fail     = misal || (dly > TO);
        exp_busy = misal ? 1 : 1 + ((dly < TO) ? dly : TO);

        @(posedge clk); #1;
        MEM_W_EN_in   = is_st;
        MEM_R_EN_in   = is_st ? 1'($urandom_range(0, 1)) : 1'b1;
        size_in       = sz;
        sign_ext_in   = sx;
        ALU_result_in = addr;
        ST_val        = st;
        sram_ready    = 1'b0;
        @(negedge clk);
        busy_cnt = int'(mem_busy);
        chk("req_busy", mem_busy, 1);
        chk("req_re", sram_re, (!is_st && !misal));
        chk("req_we", sram_we, (is_st && !misal));
        if (!misal) begin
            chk("req_addr", sram_addr, al);
            chk("req_be", sram_be, e_be);
            if (is_st) chk("req_wdata", sram_wdata, wd[31:0]);
        end

        k = 1;
        while (!misal && k <= TO) begin
            @(posedge clk); #1;
            junk_inputs();
            sram_ready = (k == dly);
            sram_rdata = (k == dly) ? rd : $urandom;
            @(negedge clk);
            busy_cnt += int'(mem_busy);
            chk("acc_re", sram_re, !is_st);
            chk("acc_we", sram_we, is_st);
            chk("acc_addr", sram_addr, al);
            chk("acc_be", sram_be, e_be);
            if (is_st) chk("acc_wdata", sram_wdata, wd[31:0]);
            chk("acc_err", mem_err, exp_err);
            chk("acc_value", MEM_read_value, exp_val);
            if (k == dly) break;
            k++;
        end

        @(posedge clk); #1;
        junk_inputs();
        sram_ready = 1'b0;
        if (fail) exp_err = 1'b1;
        else if (!is_st) exp_val = raw[31:0];
        @(negedge clk);
        chk("done_busy", mem_busy, 0);
        chk("done_re", sram_re, 0);
        chk("done_we", sram_we, 0);
        chk("done_rdv", rd_valid, (!is_st && !fail));
        chk("done_value", MEM_read_value, exp_val);
        chk("done_err", mem_err, exp_err);
        chk("busy_cycles", busy_cnt, exp_busy);

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_quiet("idle");
    endtask

    task automatic random_txns(input int cnt);
        for (int t = 0; t < cnt; t++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom,
                    1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(1, 6));
        end
    endtask

    initial begin
        exp_val = '0;
        exp_err = 1'b0;
        rst_n   = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", sram_addr, 0);
        check_quiet("rst");
        rst_n = 1'b1;

        // Directed scenarios
        run_txn(1'b0, 2'd2, 32'h10, 1'b0, 32'h0, 32'hDEADBEEF, 3);
        run_txn(1'b0, 2'd0, 32'h13, 1'b1, 32'h0, 32'h80FF1234, 2);
        run_txn(1'b0, 2'd0, 32'h13, 1'b0, 32'h0, 32'h80FF1234, 1);
        run_txn(1'b1, 2'd1, 32'h22, 1'b0, 32'h0000ABCD, 32'h0, 4);
        run_txn(1'b0, 2'd2, 32'h02, 1'b0, 32'h0, 32'h12345678, 2);
        run_txn(1'b0, 2'd1, 32'h06, 1'b1, 32'h0, 32'h8001F00F, 1);

        random_txns(40);

        // Memory never answers
        run_txn(1'b0, 2'd2, 32'h40, 1'b0, 32'h0, 32'h0, 1000);

        // Reset pulse in the middle of an ACCESS
        @(posedge clk); #1;
        MEM_R_EN_in   = 1'b1;
        size_in       = 2'd2;
        ALU_result_in = 32'h80;
        @(negedge clk);
        chk("mid_req_busy", mem_busy, 1);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        exp_val = '0;
        exp_err = 1'b0;
        chk("mid_rst_addr", sram_addr, 0);
        check_quiet("mid_rst");
        @(posedge clk); #1;
        sram_ready = 1'b1;
        sram_rdata = $urandom;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_quiet("post_rst");
        end
        @(posedge clk); #1;
        idle_inputs();

        random_txns(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_mc.md
MEM_STAGE_MC -- requirements
Module: mem_stage_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width in bits (32 or 64).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for sram_ready before error.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port MEM_R_EN_in  in  1  load request.
REQ-006 SHALL have port MEM_W_EN_in  in  1  store request.
REQ-007 SHALL have port size_in  in  2  access size: 0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
REQ-008 SHALL have port sign_ext_in  in  1  sign-extend load result.
REQ-009 SHALL have port ALU_result_in  in  DATA_W  byte address.
REQ-010 SHALL have port ST_val  in  DATA_W  store data, right-aligned.
REQ-011 SHALL have ports sram_addr out DATA_W, sram_wdata out DATA_W, sram_be out DATA_W/8, sram_re out 1, sram_we out 1: memory request.
REQ-012 SHALL have ports sram_rdata in DATA_W, sram_ready in 1: memory response.
REQ-013 SHALL have port mem_busy  out  1  pipeline freeze request.
REQ-014 SHALL have ports MEM_read_value out DATA_W, rd_valid out 1, mem_err out 1.

Function
REQ-015 SHALL implement FSM IDLE, ACCESS, DONE; MEM_R_EN_in and MEM_W_EN_in both high is treated as a store.
REQ-016 In IDLE, a request SHALL register address/data/size, drive sram_re/we and sram_be, assert mem_busy combinationally in the same cycle, and move to ACCESS.
REQ-017 In ACCESS, sram_re/we and address SHALL be held stable until sram_ready; on sram_ready, go to DONE.
REQ-018 In DONE, mem_busy SHALL be 0, rd_valid SHALL be 1 for exactly one cycle on loads, and the FSM SHALL return to IDLE; minimum latency is request cycle + 2.
REQ-019 sram_be SHALL select size bytes at offset ALU_result_in[log2(DATA_W/8)-1:0]; sram_wdata SHALL replicate ST_val lanes to that offset.
REQ-020 Load data SHALL be shifted down by the offset and zero- or sign-extended per sign_ext_in; MEM_read_value SHALL hold until the next load completes.
REQ-021 A wait counter SHALL count ACCESS cycles; reaching TIMEOUT without sram_ready SHALL set mem_err (sticky until reset), drop sram_re/we, and go to DONE with rd_valid 0.
REQ-022 New requests arriving while not IDLE SHALL be ignored (the pipeline is frozen by mem_busy).
REQ-023 Without any request, sram_re/we SHALL remain 0.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, wait counter 0, and all outputs 0, including mid-ACCESS; any outstanding memory response after reset SHALL be ignored.

Configuration
REQ-025 Macro MEM_STAGE_MISALIGN_CHK_EN defined: a half/word/dword address not aligned to its size SHALL set mem_err, issue no memory request, and complete in DONE next cycle.
REQ-026 Macro undefined: no alignment check; low address bits beyond size SHALL be ignored (forced aligned).

Structure
REQ-027 Shared package mips_pkg SHALL hold the size encoding constants and FSM state typedef.
REQ-028 Byte-lane align/extend logic SHALL be sub-module mem_lane_align (combinational), instantiated once.

Verification
REQ-029 Word load, DATA_W=32, addr 0x10, sram_ready after 3 cycles, rdata 0xDEADBEEF -> busy 4 cycles, rd_valid pulse, value 0xDEADBEEF.
REQ-030 Byte load, signed, addr 0x13, rdata 0x80FF1234 -> be 4'b1000, value 0xFFFFFF80; unsigned -> 0x00000080.
REQ-031 Half store, addr 0x22, ST_val 0x0000ABCD -> be 4'b1100, wdata 0xABCDABCD, we held until ready.
REQ-032 sram_ready never asserted, TIMEOUT=15 -> mem_err at ACCESS cycle 15, busy drops, rd_valid stays 0.
REQ-033 rst_n pulsed low in ACCESS -> immediate IDLE, outputs 0; late sram_ready ignored.
REQ-034 Macro defined, word load at 0x02 -> mem_err, sram_re never asserted; undefined -> access at 0x00.
